gctr_ctrl: RTL and testbench

Sequencing controller for the GCTR (counter-mode) datapath built on the PRESENT-80 cipher core. It latches a job (initial counter block, key, block count, final-block length), loads the key into the core, and issues one core encryption per 64-bit block. It XORs each keystream word with the incoming data word and streams the result out, masking a partial final block. It sits between the GCM top-level sequencer and a single `present80` instance, replacing free-running round counting with explicit handshakes.

---
 rtl/gctr_pkg.sv | 22 ++
 rtl/gctr_ctrl_if.sv | 28 ++
 rtl/gctr_ctr_inc.sv | 16 +
 rtl/gctr_ctrl.sv | 152 +++++++++++++++
 tb/tb_gctr_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/gctr_pkg.sv
// Shared types and helpers for the GCTR sequencing controller: state encoding,
// datapath widths and the final-block mask.
package gctr_pkg;

  localparam int BLK_W = 64;
  localparam int KEY_W = 80;
  localparam int LEN_W = 7;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_ENC, S_WAIT, S_XOR, S_OUT, S_DONE
  } state_e;

  // Keep the top 'len' bits of the final block; len 0 (or anything past 64) means a full block.
  function automatic logic [BLK_W-1:0] gen_mask(input logic [LEN_W-1:0] len, input logic last);
    logic [BLK_W-1:0] m;
    m = '1;
    if (last && len != '0 && len < LEN_W'(BLK_W))
      m = ~({BLK_W{1'b1}} >> len);
    return m;
  endfunction

endpackage

// File: rtl/gctr_ctrl_if.sv
// Data-stream and cipher-core handshake bundle for gctr_ctrl.
interface gctr_ctrl_if;
  import gctr_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;
  logic             core_load;
  logic [KEY_W-1:0] core_key;
  logic             core_start;
  logic [BLK_W-1:0] core_in;
  logic             core_done;
  logic [BLK_W-1:0] core_out;

  modport master (
    input  in_valid, in_data, out_ready, core_done, core_out,
    output in_ready, out_valid, out_data, core_load, core_key, core_start, core_in
  );

  modport slave (
    output in_valid, in_data, out_ready, core_done, core_out,
    input  in_ready, out_valid, out_data, core_load, core_key, core_start, core_in
  );

endinterface

// File: rtl/gctr_ctr_inc.sv
// Counter-block increment. Define GCTR_INC32_EN for the GCM inc32 form
// (low word wraps, high word fixed); otherwise the whole block increments.
module gctr_ctr_inc
  import gctr_pkg::*;
(
  input  logic [BLK_W-1:0] cb,
  output logic [BLK_W-1:0] cb_inc
);

`ifdef GCTR_INC32_EN
  assign cb_inc = {cb[BLK_W-1:32], cb[31:0] + 32'd1};
`else
  assign cb_inc = cb + BLK_W'(1);
`endif

endmodule

// File: rtl/gctr_ctrl.sv
// GCTR sequencer around a PRESENT-80 core: key load, one encrypt per block,
// keystream XOR with masked final block. Counter width set by GCTR_INC32_EN.
module gctr_ctrl
  import gctr_pkg::*;
#(
  parameter int NBLK_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [BLK_W-1:0]  icb,
  input  logic [KEY_W-1:0]  key,
  input  logic [NBLK_W-1:0] num_blk,
  input  logic [LEN_W-1:0]  last_len,
  output logic              busy,
  output logic              done,
  gctr_ctrl_if.master       bus
);

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   cb_q, cb_d, cb_inc;
  logic [BLK_W-1:0]   ks_q, ks_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [NBLK_W-1:0]  nblk_q, nblk_d;
  logic [NBLK_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [BLK_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               core_load_q, core_load_d;
  logic               core_start_q, core_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               last_blk;

  gctr_ctr_inc u_inc (.cb(cb_q), .cb_inc(cb_inc));

  assign last_blk = (blk_cnt_q == nblk_q - NBLK_W'(1));

  always_comb begin
    state_d      = state_q;
    cb_d         = cb_q;
    ks_d         = ks_q;
    key_d        = key_q;
    nblk_d       = nblk_q;
    blk_cnt_d    = blk_cnt_q;
    len_d        = len_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    in_ready_d   = in_ready_q;
    busy_d       = busy_q;
    core_load_d  = 1'b0;
    core_start_d = 1'b0;
    done_d       = 1'b0;
    // Strobes are set on the transition so they appear registered in the target state.
    unique case (state_q)
      S_IDLE: if (start) begin
        cb_d      = icb;
        key_d     = key;
        nblk_d    = num_blk;
        len_d     = last_len;
        blk_cnt_d = '0;
        busy_d    = 1'b1;
        if (num_blk == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = S_KEY;
          core_load_d = 1'b1;
        end
      end
      S_KEY: begin
        state_d      = S_ENC;
        core_start_d = 1'b1;
      end
      S_ENC: state_d = S_WAIT;
      S_WAIT: if (bus.core_done) begin
        ks_d       = bus.core_out;
        in_ready_d = 1'b1;
        state_d    = S_XOR;
      end
      S_XOR: if (bus.in_valid) begin
        out_data_d  = (bus.in_data ^ ks_q) & gen_mask(len_q, last_blk);
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
        state_d     = S_OUT;
      end
      S_OUT: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        if (last_blk) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          blk_cnt_d    = blk_cnt_q + NBLK_W'(1);
          cb_d         = cb_inc;
          state_d      = S_ENC;
          core_start_d = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cb_q         <= '0;
      ks_q         <= '0;
      key_q        <= '0;
      nblk_q       <= '0;
      blk_cnt_q    <= '0;
      len_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      core_load_q  <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cb_q         <= cb_d;
      ks_q         <= ks_d;
      key_q        <= key_d;
      nblk_q       <= nblk_d;
      blk_cnt_q    <= blk_cnt_d;
      len_q        <= len_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      core_load_q  <= core_load_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.core_load  = core_load_q;
  assign bus.core_key   = key_q;
  assign bus.core_start = core_start_q;
  assign bus.core_in    = cb_q;

endmodule

// File: tb/tb_gctr_ctrl.sv
// Directed + randomized bench for gctr_ctrl with a fixed-latency (L=4) echo core.
module tb_gctr_ctrl;
  import gctr_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] icb = '0;
  logic [79:0] key = '0;
  logic [7:0]  num_blk = '0;
  logic [6:0]  last_len = '0;
  logic        busy, done;

  gctr_ctrl_if bus();

  gctr_ctrl #(.NBLK_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .icb(icb), .key(key),
    .num_blk(num_blk), .last_len(last_len), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Echo core: core_done exactly 4 cycles after core_start, returning the counter block.
  logic [2:0]  lat_cnt = '0;
  logic [63:0] lat_data = '0;
  logic        cd_q = 1'b0;
  logic [63:0] co_q = '0;
  assign bus.core_done = cd_q;
  assign bus.core_out  = co_q;
  always @(posedge clk) begin
    if (bus.core_start) begin
      lat_cnt  <= 3'd3;
      lat_data <= bus.core_in;
    end else if (lat_cnt != 0) lat_cnt <= lat_cnt - 3'd1;
    cd_q <= (lat_cnt == 3'd1) && !bus.core_start;
    co_q <= (lat_cnt == 3'd1) ? lat_data : '0;
  end

  int n_load = 0, n_start = 0, n_done = 0;
  always @(negedge clk) begin
    if (bus.core_load)  n_load  <= n_load + 1;
    if (bus.core_start) n_start <= n_start + 1;
    if (done)           n_done  <= n_done + 1;
  end

  int nvec = 0, nerr = 0;
  int exp_load = 0, exp_start = 0, exp_done = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_ks(input logic [63:0] base, input int i);
`ifdef GCTR_INC32_EN
    logic [31:0] lo;
    lo = base[31:0] + 32'(i);
    return {base[63:32], lo};
`else
    return base + 64'(i);
`endif
  endfunction

  function automatic logic [63:0] ref_mask(input logic [6:0] len, input bit last);
    logic [63:0] m;
    int nb;
    nb = (len == 0 || len > 64) ? 64 : int'(len);
    for (int b = 0; b < 64; b++) m[63-b] = last ? (b < nb) : 1'b1;
    return m;
  endfunction

  // mode: 0 random data, 1 all zeros, 2 all ones
  task automatic run_job(input logic [63:0] j_icb, input logic [79:0] j_key, input int n,
                         input logic [6:0] len, input int st_lo, input int st_hi,
                         input int mode, input bit poke);
    logic [63:0] data, expv;
    int w, k;
    exp_done++;
    if (n > 0) begin exp_load++; exp_start += n; end
    @(negedge clk);
    start = 1'b1; icb = j_icb; key = j_key; num_blk = 8'(n); last_len = len;
    @(negedge clk);
    start = 1'b0; icb = {$urandom, $urandom}; key = {$urandom, $urandom, $urandom};
    num_blk = 8'($urandom); last_len = 7'($urandom);
    chk("busy_t1", busy, 1);
    if (n == 0) begin
      chk("empty_done_t1", done, 1);
      chk("empty_no_load", bus.core_load, 0);
      @(negedge clk);
      chk("empty_done_drop", done, 0);
      chk("empty_no_start", bus.core_start, 0);
      chk("empty_busy_drop", busy, 0);
      return;
    end
    chk("core_load_t1", bus.core_load, 1);
    chk("core_key", bus.core_key, j_key);
    @(negedge clk);
    chk("core_start_t2", bus.core_start, 1);
    chk("core_in_blk0", bus.core_in, j_icb);
    for (int i = 0; i < n; i++) begin
      data = (mode == 1) ? 64'h0 : (mode == 2) ? '1 : {$urandom, $urandom};
      expv = (data ^ ref_ks(j_icb, i)) & ref_mask(len, i == n - 1);
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      if (poke && i == 0) begin start = 1'b1; icb = ~j_icb; num_blk = 8'd0; end
      w = 0;
      while (!bus.in_ready && w < 40) begin
        @(negedge clk);
        w++;
        if (w == 1) start = 1'b0;
      end
      if (!bus.in_ready) begin chk("in_ready_timeout", 0, 1); return; end
      chk("ks_latency", 80'(w), 5);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, expv);
      chk("in_ready_in_out", bus.in_ready, 0);
      k = $urandom_range(st_hi, st_lo);
      for (int j = 0; j < k; j++) begin
        @(negedge clk);
        chk("stall_data", bus.out_data, expv);
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_no_start", bus.core_start, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("out_valid_drop", bus.out_valid, 0);
      if (i < n - 1) begin
        chk("next_core_start", bus.core_start, 1);
        chk("next_core_in", bus.core_in, ref_ks(j_icb, i + 1));
      end else begin
        chk("done_pulse", done, 1);
        @(negedge clk);
        chk("done_drop", done, 0);
        chk("busy_drop", busy, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_core_in", bus.core_in, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_job(64'hABAC8CA6000AA98A, 80'h0123456789ABCDEF0123, 2, 7'd64, 0, 0, 1, 1'b0);
    run_job(64'h0, 80'h5, 1, 7'd12, 0, 1, 2, 1'b0);
    run_job(64'h12345678FFFFFFFF, 80'h77, 2, 7'd0, 0, 0, 1, 1'b0);
    run_job(64'hFEDCBA9876543210, 80'h99, 2, 7'd33, 10, 10, 0, 1'b1);
    run_job(64'h1, 80'h1, 0, 7'd0, 0, 0, 0, 1'b0);
    run_job(64'hFFFFFFFFFFFFFFFE, 80'h3, 3, 7'd1, 0, 2, 0, 1'b0);

    // Reset during WAIT of block 1 of 3: abort with no done; stale core_done lands in IDLE.
    exp_load++; exp_start++;
    @(negedge clk);
    start = 1'b1; icb = 64'hDEAD_BEEF_0000_0001; key = 80'hA5; num_blk = 8'd3; last_len = 7'd64;
    @(negedge clk); start = 1'b0;
    @(negedge clk); chk("abort_core_start", bus.core_start, 1);
    bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom};
    @(negedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_core_in", bus.core_in, 0);
    chk("abort_core_key", bus.core_key, 0);
    @(negedge clk); reset_n = 1'b1; bus.in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle_busy", busy, 0);
    end
    run_job(64'h0000000100000002, 80'hBEEF, 3, 7'd8, 0, 1, 0, 1'b0);

    for (int r = 0; r < 6; r++)
      run_job({$urandom, $urandom}, {$urandom, $urandom, $urandom},
              $urandom_range(4, 0), 7'($urandom_range(64, 0)), 0, 3, 0, r[0]);

    repeat (2) @(negedge clk);
    chk("total_core_load", 80'(n_load), 80'(exp_load));
    chk("total_core_start", 80'(n_start), 80'(exp_start));
    chk("total_done", 80'(n_done), 80'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
